// File: rtl/robocup_bldc.sv
// Six-step BLDC commutator: synchronises the Hall code, picks a source/sink phase
// pair, PWMs the source high side, holds the sink low side, and inserts dead time.
module robocup_bldc #(
   parameter int DUTY_CYCLE_WIDTH = 8,
   parameter int DEAD_TIME        = 4
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [2:0]                  h,
   input  logic [DUTY_CYCLE_WIDTH-1:0] duty_cycle,
   output logic [2:0]                  phaseH,
   output logic [2:0]                  phaseL
);

   localparam int DT_W = (DEAD_TIME < 1) ? 1 : $clog2(DEAD_TIME + 1);
   localparam logic [DUTY_CYCLE_WIDTH-1:0] PWM_MAX = '1;

   typedef enum logic [2:0] {
      STEP_FAULT,
      STEP_AB,
      STEP_AC,
      STEP_BC,
      STEP_BA,
      STEP_CA,
      STEP_CB
   } step_t;

   logic [2:0]                  h_meta_reg;
   logic [2:0]                  h_s_reg;
   step_t                       step_reg;
   step_t                       step_dec;
   logic [DT_W-1:0]             dead_reg;
   logic [DT_W-1:0]             dead_next;
   logic [DUTY_CYCLE_WIDTH-1:0] pwm_cnt_reg;
   logic [DUTY_CYCLE_WIDTH-1:0] duty_reg;
   logic [2:0]                  src_sel;
   logic [2:0]                  snk_sel;
   logic [2:0]                  phase_h_next;
   logic [2:0]                  phase_l_next;
   logic                        step_change;
   logic                        gate_on;
   logic                        pwm_on;

   always_comb begin
      step_dec = STEP_FAULT;
      src_sel  = 3'b000;
      snk_sel  = 3'b000;
      case (h_s_reg)
         3'b001:  begin step_dec = STEP_AB; src_sel = 3'b001; snk_sel = 3'b010; end
         3'b011:  begin step_dec = STEP_AC; src_sel = 3'b001; snk_sel = 3'b100; end
         3'b010:  begin step_dec = STEP_BC; src_sel = 3'b010; snk_sel = 3'b100; end
         3'b110:  begin step_dec = STEP_BA; src_sel = 3'b010; snk_sel = 3'b001; end
         3'b100:  begin step_dec = STEP_CA; src_sel = 3'b100; snk_sel = 3'b001; end
         3'b101:  begin step_dec = STEP_CB; src_sel = 3'b100; snk_sel = 3'b010; end
         default: begin step_dec = STEP_FAULT; src_sel = 3'b000; snk_sel = 3'b000; end
      endcase
   end

   // Gates are computed from the post-update dead counter so the outputs drop on
   // the same edge the new step is latched and stay off for exactly DEAD_TIME clocks.
   always_comb begin
      step_change = (step_dec != step_reg);
      if (step_change)
         dead_next = DT_W'(DEAD_TIME);
      else if (dead_reg != '0)
         dead_next = dead_reg - 1'b1;
      else
         dead_next = '0;
      gate_on = (step_dec != STEP_FAULT) && (dead_next == '0);
      pwm_on  = (pwm_cnt_reg < duty_reg);
   end

   for (genvar gi = 0; gi < 3; gi++) begin : g_phase
      assign phase_h_next[gi] = gate_on & pwm_on & src_sel[gi];
      assign phase_l_next[gi] = gate_on & snk_sel[gi];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         h_meta_reg  <= 3'b000;
         h_s_reg     <= 3'b000;
         step_reg    <= STEP_FAULT;
         dead_reg    <= '0;
         pwm_cnt_reg <= '0;
         duty_reg    <= '0;
         phaseH      <= 3'b000;
         phaseL      <= 3'b000;
      end else begin
         h_meta_reg  <= h;
         h_s_reg     <= h_meta_reg;
         step_reg    <= step_dec;
         dead_reg    <= dead_next;
         pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
         if (pwm_cnt_reg == PWM_MAX)
            duty_reg <= duty_cycle;
         phaseH      <= phase_h_next;
         phaseL      <= phase_l_next;
      end
   end

endmodule

// File: tb/tb_robocup_bldc.sv
// Scoreboard bench for robocup_bldc: stimulus queues per-window expected gate
// activity counts; the monitor accumulates observed counts and compares.
module tb_robocup_bldc;

   logic       clock = 1'b0;
   logic       reset;
   logic [2:0] h;
   logic [7:0] duty_cycle;
   logic [2:0] phaseH;
   logic [2:0] phaseL;

   robocup_bldc #(.DUTY_CYCLE_WIDTH(8), .DEAD_TIME(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .h          (h),
      .duty_cycle (duty_cycle),
      .phaseH     (phaseH),
      .phaseL     (phaseL)
   );

   always #5 clock = ~clock;

   // Edge index: the three initial reset edges are -2..0, edge 1 is the first
   // edge with the PWM counter at 0.
   int edge_n = -3;
   always @(posedge clock) edge_n <= edge_n + 1;

   localparam int END_N = 11100;

   typedef struct {
      logic [8*8-1:0] name;
      int start;
      int len;
      int eh0, eh1, eh2;
      int el0, el1, el2;
      int ez;
   } win_t;

   win_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic push(input logic [8*8-1:0] name, input int start, input int len,
                       input int h0, input int h1, input int h2,
                       input int l0, input int l1, input int l2, input int z);
      win_t w;
      w.name = name; w.start = start; w.len = len;
      w.eh0 = h0; w.eh1 = h1; w.eh2 = h2;
      w.el0 = l0; w.el1 = l1; w.el2 = l2;
      w.ez = z;
      sb.push_back(w);
   endtask

   task automatic wait_edge(input int t);
      while (edge_n < t) @(negedge clock);
   endtask

   // ---------------- stimulus ----------------
   int          step_t0;
   logic [2:0]  codes [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};
   int          src_t [6] = '{0, 0, 1, 1, 2, 2};
   int          snk_t [6] = '{1, 2, 2, 0, 0, 1};

   initial begin
      int e_h [3];
      int e_l [3];
      reset      = 1'b1;
      h          = 3'b000;
      duty_cycle = 8'h80;
      push("reset", 0, 1, 0, 0, 0, 0, 0, 0, 1);
      push("fault0", 1, 2048, 0, 0, 0, 0, 0, 0, 2048);
      wait_edge(0);
      reset = 1'b0;

      for (int i = 0; i < 6; i++) begin
         step_t0 = 2048 + 1024 * i;
         wait_edge(step_t0);
         h = codes[i];
         e_l = '{0, 0, 0};
         if (i > 0) e_l[snk_t[i-1]] = 2;
         push("trans", step_t0 + 1, 6, -1, -1, -1, e_l[0], e_l[1], e_l[2], (i == 0) ? 6 : 4);
         e_h = '{0, 0, 0};
         e_l = '{0, 0, 0};
         e_h[src_t[i]] = 256;
         e_l[snk_t[i]] = 512;
         push("steady", step_t0 + 7, 512, e_h[0], e_h[1], e_h[2], e_l[0], e_l[1], e_l[2], 0);
      end

      push("duty80", 8193, 256, 0, 0, 128, 0, 256, 0, 0);
      push("duty40", 8449, 256, 0, 0, 64, 0, 256, 0, 0);
      wait_edge(8256);
      duty_cycle = 8'h40;

      wait_edge(8714);
      duty_cycle = 8'h00;
      push("duty00", 8961, 256, 0, 0, 0, 0, 256, 0, 0);

      wait_edge(9000);
      duty_cycle = 8'hFF;
      push("dutyFF", 9217, 256, 0, 0, 255, 0, 256, 0, 0);

      wait_edge(9500);
      h = 3'b111;
      push("hall111", 9503, 200, 0, 0, 0, 0, 0, 0, 200);

      wait_edge(9800);
      h = 3'b101;
      push("recover", 9801, 6, 0, 0, 0, 0, 0, 0, 6);
      push("recovst", 9807, 512, 0, 0, 510, 0, 512, 0, 0);
      push("prerst", 10500, 1, 0, 0, 1, 0, 1, 0, 0);
      push("midrst", 10501, 1, 0, 0, 0, 0, 0, 0, 1);
      push("resync", 10502, 7, 0, 0, 0, 0, 0, 0, 7);
      push("duty0rs", 10509, 250, 0, 0, 0, 0, 250, 0, 0);
      push("dutyFF2", 10759, 256, 0, 0, 255, 0, 256, 0, 0);

      wait_edge(10500);
      reset = 1'b1;
      wait_edge(10502);
      reset = 1'b0;
   end

   // ---------------- monitor ----------------
   task automatic chk(input logic [8*8-1:0] name, input string what, input int act, input int exp);
      if (exp >= 0) begin
         checks++;
         if (act != exp) begin
            failures++;
            $display("FAIL %0s %0s actual=%0d required=%0d", name, what, act, exp);
         end
      end
   endtask

   initial begin
      int   ah [3];
      int   al [3];
      int   av;
      int   az;
      win_t w;
      ah = '{0, 0, 0};
      al = '{0, 0, 0};
      av = 0;
      az = 0;
      forever begin
         @(negedge clock);
         if (sb.size() > 0 && edge_n >= sb[0].start) begin
            for (int i = 0; i < 3; i++) begin
               if (phaseH[i] === 1'b1) ah[i]++;
               if (phaseL[i] === 1'b1) al[i]++;
               if ((phaseH[i] & phaseL[i]) !== 1'b0) av++;
            end
            if ($countones(phaseH) > 1 || $countones(phaseL) > 1) av++;
            if (phaseH === 3'b000 && phaseL === 3'b000) az++;
            if (edge_n == sb[0].start + sb[0].len - 1) begin
               w = sb.pop_front();
               chk(w.name, "h0_on", ah[0], w.eh0);
               chk(w.name, "h1_on", ah[1], w.eh1);
               chk(w.name, "h2_on", ah[2], w.eh2);
               chk(w.name, "l0_on", al[0], w.el0);
               chk(w.name, "l1_on", al[1], w.el1);
               chk(w.name, "l2_on", al[2], w.el2);
               chk(w.name, "all_off", az, w.ez);
               chk(w.name, "overlap", av, 0);
               $display("window %0s start=%0d len=%0d h_on=%0d/%0d/%0d l_on=%0d/%0d/%0d off=%0d",
                        w.name, w.start, w.len, ah[0], ah[1], ah[2], al[0], al[1], al[2], az);
               ah = '{0, 0, 0};
               al = '{0, 0, 0};
               av = 0;
               az = 0;
            end
         end
         if (edge_n >= END_N) begin
            chk("drain", "pending", sb.size(), 0);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
         end
      end
   end

endmodule
